// File: rtl/lab1_response_checker_if.sv
// Bus between the Lab1 stimulus side (master) and lab1_response_checker (slave).
// LAB1_CHK_SIGNATURE_EN adds the MISR signature signal.
interface lab1_response_checker_if;
    logic        start;
    logic        vec_valid;
    logic [3:0]  vec;
    logic        f;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] truth_table;
    logic [15:0] cover_mask;
    logic [4:0]  err_count;
    logic        first_err_valid;
    logic [3:0]  first_err_vec;
`ifdef LAB1_CHK_SIGNATURE_EN
    logic [15:0] signature;

    modport master (
        output start, vec_valid, vec, f,
        input  busy, done, pass, truth_table, cover_mask, err_count,
               first_err_valid, first_err_vec, signature
    );

    modport slave (
        input  start, vec_valid, vec, f,
        output busy, done, pass, truth_table, cover_mask, err_count,
               first_err_valid, first_err_vec, signature
    );
`else
    modport master (
        output start, vec_valid, vec, f,
        input  busy, done, pass, truth_table, cover_mask, err_count,
               first_err_valid, first_err_vec
    );

    modport slave (
        input  start, vec_valid, vec, f,
        output busy, done, pass, truth_table, cover_mask, err_count,
               first_err_valid, first_err_vec
    );
`endif
endinterface

// File: rtl/lab1_response_checker.sv
// Samples a Lab1 DUT output per settled input vector, builds its truth table and checks it against GOLDEN.
// Optional MISR signature over the sample stream is enabled by defining LAB1_CHK_SIGNATURE_EN.
module lab1_response_checker #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [15:0] GOLDEN        = 16'hB4E1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lab1_response_checker_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [7:0] LP_CNT_LAST = 8'(SETTLE_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_cnt;
    logic [3:0]  r_cur_vec;
    logic [3:0]  r_last_vec;
    logic        r_have_last;
    logic [15:0] r_truth;
    logic [15:0] r_cover;
    logic [4:0]  r_err_count;
    logic        r_first_err_valid;
    logic [3:0]  r_first_err_vec;

    logic        w_accept;
    logic        w_stable;
    logic        w_settled;
    logic        w_mismatch;
    logic [15:0] w_cover_upd;

    always_comb begin
        w_accept    = bus.vec_valid && (!r_have_last || (bus.vec != r_last_vec));
        w_stable    = bus.vec_valid && (bus.vec == r_cur_vec);
        w_settled   = w_stable && (r_cnt == LP_CNT_LAST);
        w_mismatch  = (bus.f != GOLDEN[r_cur_vec]);
        w_cover_upd = r_cover | (16'd1 << r_cur_vec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // start overrides everything, including a pending sample.
    always_comb begin
        w_next_state = r_state;
        if (bus.start) begin
            w_next_state = ST_ARMED;
        end else begin
            case (r_state)
                ST_IDLE:   w_next_state = ST_IDLE;
                ST_ARMED: begin
                    if (w_accept) begin
                        w_next_state = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!bus.vec_valid) begin
                        w_next_state = ST_ARMED;
                    end else if (w_settled) begin
                        w_next_state = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (w_cover_upd == 16'hFFFF) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_ARMED;
                    end
                end
                ST_DONE:   w_next_state = ST_DONE;
                default:   w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt             <= 8'd0;
            r_cur_vec         <= 4'd0;
            r_last_vec        <= 4'd0;
            r_have_last       <= 1'b0;
            r_truth           <= 16'd0;
            r_cover           <= 16'd0;
            r_err_count       <= 5'd0;
            r_first_err_valid <= 1'b0;
            r_first_err_vec   <= 4'd0;
        end else if (bus.start) begin
            r_cnt             <= 8'd0;
            r_have_last       <= 1'b0;
            r_truth           <= 16'd0;
            r_cover           <= 16'd0;
            r_err_count       <= 5'd0;
            r_first_err_valid <= 1'b0;
            r_first_err_vec   <= 4'd0;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (w_accept) begin
                        r_cur_vec <= bus.vec;
                        r_cnt     <= 8'd0;
                    end
                end
                ST_SETTLE: begin
                    // A changed vector restarts the settle window from scratch.
                    if (!w_stable) begin
                        r_cnt <= 8'd0;
                        if (bus.vec_valid) begin
                            r_cur_vec <= bus.vec;
                        end
                    end else if (!w_settled) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    r_truth[r_cur_vec] <= bus.f;
                    r_cover            <= w_cover_upd;
                    r_last_vec         <= r_cur_vec;
                    r_have_last        <= 1'b1;
                    if (w_mismatch) begin
                        if (r_err_count != 5'd31) begin
                            r_err_count <= r_err_count + 5'd1;
                        end
                        if (!r_first_err_valid) begin
                            r_first_err_valid <= 1'b1;
                            r_first_err_vec   <= r_cur_vec;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef LAB1_CHK_SIGNATURE_EN
    logic [15:0] r_signature;
    logic [15:0] w_sig_next;

    always_comb begin
        w_sig_next = {r_signature[14:0],
                      r_signature[15] ^ r_signature[13] ^ r_signature[12] ^ r_signature[10]}
                     ^ {11'b0, bus.f, r_cur_vec};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_signature <= 16'hFFFF;
        end else if (bus.start) begin
            r_signature <= 16'hFFFF;
        end else if (r_state == ST_SAMPLE) begin
            r_signature <= w_sig_next;
        end
    end

    assign bus.signature = r_signature;
`endif

    assign bus.busy            = (r_state == ST_ARMED) || (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    assign bus.done            = (r_state == ST_DONE);
    assign bus.pass            = (r_state == ST_DONE) && (r_err_count == 5'd0);
    assign bus.truth_table     = r_truth;
    assign bus.cover_mask      = r_cover;
    assign bus.err_count       = r_err_count;
    assign bus.first_err_valid = r_first_err_valid;
    assign bus.first_err_vec   = r_first_err_vec;

endmodule

// File: tb/tb_lab1_response_checker.sv
// Directed self-checking bench for lab1_response_checker (default SETTLE_CYCLES=4, GOLDEN=16'hB4E1).
// Also covers the signature output when LAB1_CHK_SIGNATURE_EN is defined.
module tb_lab1_response_checker;

    localparam int          SETTLE = 4;
    localparam logic [15:0] GOLD   = 16'hB4E1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nCompared = 0;
    int   nMismatched = 0;

    lab1_response_checker_if busIf ();

    lab1_response_checker #(
        .SETTLE_CYCLES (SETTLE),
        .GOLDEN        (GOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives one vector starting at the current negedge and holds it for 'hold' clocks.
    task automatic applyStimulus(input logic [3:0] v, input logic fv, input int hold);
        busIf.vec_valid = 1'b1;
        busIf.vec       = v;
        busIf.f         = fv;
        repeat (hold) @(negedge clk);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        busIf.vec_valid = 1'b0;
        busIf.start     = 1'b1;
        @(negedge clk);
        busIf.start     = 1'b0;
    endtask

    task automatic test_reset();
        busIf.start     = 1'b0;
        busIf.vec_valid = 1'b0;
        busIf.vec       = 4'd0;
        busIf.f         = 1'b0;
        rst_n           = 1'b0;
        repeat (2) @(negedge clk);
        nCompared++;
        if (busIf.busy !== 1'b0 || busIf.done !== 1'b0 || busIf.pass !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_flags: got busy=%b done=%b pass=%b want 0 0 0", busIf.busy, busIf.done, busIf.pass);
        end
        nCompared++;
        if (busIf.truth_table !== 16'h0 || busIf.cover_mask !== 16'h0 || busIf.err_count !== 5'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_results: got tt=%h cov=%h err=%0d want 0 0 0", busIf.truth_table, busIf.cover_mask, busIf.err_count);
        end
        nCompared++;
        if (busIf.first_err_valid !== 1'b0 || busIf.first_err_vec !== 4'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_first_err: got v=%b vec=%h want 0 0", busIf.first_err_valid, busIf.first_err_vec);
        end
`ifdef LAB1_CHK_SIGNATURE_EN
        nCompared++;
        if (busIf.signature !== 16'hFFFF) begin
            nMismatched++;
            $display("[TB] FAIL reset_signature: got %h want ffff", busIf.signature);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(4'd2, 1'b0, 8);
        nCompared++;
        if (busIf.busy !== 1'b0 || busIf.cover_mask !== 16'h0) begin
            nMismatched++;
            $display("[TB] FAIL idle_ignores_vec: got busy=%b cov=%h want 0 0000", busIf.busy, busIf.cover_mask);
        end
    endtask

    task automatic test_ascending();
        logic [15:0] g;
        g = GOLD;
        pulseStart();
        nCompared++;
        if (busIf.busy !== 1'b1 || busIf.done !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL armed_flags: got busy=%b done=%b want 1 0", busIf.busy, busIf.done);
        end
        for (int v = 0; v < 16; v++) applyStimulus(4'(v), g[v], 8);
        nCompared++;
        if (busIf.done !== 1'b1 || busIf.pass !== 1'b1 || busIf.busy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL sweep_flags: got done=%b pass=%b busy=%b want 1 1 0", busIf.done, busIf.pass, busIf.busy);
        end
        nCompared++;
        if (busIf.truth_table !== 16'hB4E1 || busIf.cover_mask !== 16'hFFFF) begin
            nMismatched++;
            $display("[TB] FAIL sweep_table: got tt=%h cov=%h want b4e1 ffff", busIf.truth_table, busIf.cover_mask);
        end
        nCompared++;
        if (busIf.err_count !== 5'd0 || busIf.first_err_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL sweep_errors: got err=%0d fev=%b want 0 0", busIf.err_count, busIf.first_err_valid);
        end
        applyStimulus(4'd5, ~g[5], 8);
        nCompared++;
        if (busIf.done !== 1'b1 || busIf.truth_table !== 16'hB4E1 || busIf.err_count !== 5'd0) begin
            nMismatched++;
            $display("[TB] FAIL done_ignores_vec: got done=%b tt=%h err=%0d want 1 b4e1 0", busIf.done, busIf.truth_table, busIf.err_count);
        end
    endtask

    task automatic test_errors();
        logic [15:0] g;
        g = GOLD;
        pulseStart();
        for (int v = 0; v < 16; v++) applyStimulus(4'(v), g[v] ^ ((v == 3) || (v == 9)), 8);
        nCompared++;
        if (busIf.done !== 1'b1 || busIf.pass !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL err_flags: got done=%b pass=%b want 1 0", busIf.done, busIf.pass);
        end
        nCompared++;
        if (busIf.err_count !== 5'd2) begin
            nMismatched++;
            $display("[TB] FAIL err_count: got %0d want 2", busIf.err_count);
        end
        nCompared++;
        if (busIf.first_err_valid !== 1'b1 || busIf.first_err_vec !== 4'd3) begin
            nMismatched++;
            $display("[TB] FAIL err_first: got v=%b vec=%0d want 1 3", busIf.first_err_valid, busIf.first_err_vec);
        end
        nCompared++;
        if (busIf.truth_table !== 16'hB6E9) begin
            nMismatched++;
            $display("[TB] FAIL err_table: got %h want b6e9", busIf.truth_table);
        end
    endtask

    task automatic test_glitch();
        logic [15:0] g;
        g = GOLD;
        pulseStart();
        nCompared++;
        if (busIf.cover_mask !== 16'h0 || busIf.err_count !== 5'd0 || busIf.first_err_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL start_clears: got cov=%h err=%0d fev=%b want 0000 0 0", busIf.cover_mask, busIf.err_count, busIf.first_err_valid);
        end
        applyStimulus(4'd5, g[5], 2);
        applyStimulus(4'd6, g[6], 8);
        nCompared++;
        if (busIf.cover_mask !== 16'h0040 || busIf.truth_table !== 16'h0040) begin
            nMismatched++;
            $display("[TB] FAIL glitch_cover: got cov=%h tt=%h want 0040 0040", busIf.cover_mask, busIf.truth_table);
        end
        nCompared++;
        if (busIf.busy !== 1'b1 || busIf.done !== 1'b0 || busIf.err_count !== 5'd0) begin
            nMismatched++;
            $display("[TB] FAIL glitch_flags: got busy=%b done=%b err=%0d want 1 0 0", busIf.busy, busIf.done, busIf.err_count);
        end
    endtask

    task automatic test_partial_then_last();
        logic [15:0] g;
        int          doneAt;
        g      = GOLD;
        doneAt = 0;
        pulseStart();
        for (int v = 0; v < 15; v++) applyStimulus(4'(v), g[v], 8);
        nCompared++;
        if (busIf.cover_mask !== 16'h7FFF || busIf.truth_table !== 16'h34E1) begin
            nMismatched++;
            $display("[TB] FAIL partial_cover: got cov=%h tt=%h want 7fff 34e1", busIf.cover_mask, busIf.truth_table);
        end
        nCompared++;
        if (busIf.done !== 1'b0 || busIf.busy !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL partial_flags: got done=%b busy=%b want 0 1", busIf.done, busIf.busy);
        end
        busIf.vec_valid = 1'b1;
        busIf.vec       = 4'd15;
        busIf.f         = g[15];
        for (int i = 1; i <= SETTLE + 2; i++) begin
            @(negedge clk);
            if (busIf.done === 1'b1) begin
                doneAt = i;
                break;
            end
        end
        nCompared++;
        if (doneAt != SETTLE + 2) begin
            nMismatched++;
            $display("[TB] FAIL last_latency: got done after %0d clocks (0 = timeout) want %0d", doneAt, SETTLE + 2);
        end
        nCompared++;
        if (busIf.pass !== 1'b1 || busIf.cover_mask !== 16'hFFFF) begin
            nMismatched++;
            $display("[TB] FAIL last_result: got pass=%b cov=%h want 1 ffff", busIf.pass, busIf.cover_mask);
        end
    endtask

    task automatic test_duplicates();
        pulseStart();
        applyStimulus(4'd3, 1'b0, 8);
        applyStimulus(4'd4, 1'b1, 8);
        applyStimulus(4'd3, 1'b1, 16);
        nCompared++;
        if (busIf.err_count !== 5'd2) begin
            nMismatched++;
            $display("[TB] FAIL dup_err_count: got %0d want 2", busIf.err_count);
        end
        nCompared++;
        if (busIf.truth_table !== 16'h0018 || busIf.cover_mask !== 16'h0018 || busIf.first_err_vec !== 4'd4) begin
            nMismatched++;
            $display("[TB] FAIL dup_table: got tt=%h cov=%h fe=%0d want 0018 0018 4", busIf.truth_table, busIf.cover_mask, busIf.first_err_vec);
        end
    endtask

    task automatic test_start_priority();
        logic [15:0] g;
        g = GOLD;
        pulseStart();
        applyStimulus(4'd1, g[1], 8);
        nCompared++;
        if (busIf.cover_mask !== 16'h0002) begin
            nMismatched++;
            $display("[TB] FAIL prio_pre: got cov=%h want 0002", busIf.cover_mask);
        end
        applyStimulus(4'd2, g[2], 5);
        busIf.start = 1'b1;
        @(negedge clk);
        busIf.start = 1'b0;
        nCompared++;
        if (busIf.cover_mask !== 16'h0000 || busIf.busy !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL prio_start: got cov=%h busy=%b want 0000 1", busIf.cover_mask, busIf.busy);
        end
        repeat (8) @(negedge clk);
        nCompared++;
        if (busIf.cover_mask !== 16'h0004) begin
            nMismatched++;
            $display("[TB] FAIL prio_resample: got cov=%h want 0004", busIf.cover_mask);
        end
    endtask

    task automatic test_reset_midrun();
        logic [15:0] g;
        g = GOLD;
        pulseStart();
        for (int v = 0; v < 7; v++) applyStimulus(4'(v), g[v], 8);
        applyStimulus(4'd7, g[7], 2);
        #2;
        rst_n = 1'b0;
        #1;
        nCompared++;
        if (busIf.busy !== 1'b0 || busIf.done !== 1'b0 || busIf.cover_mask !== 16'h0 || busIf.truth_table !== 16'h0) begin
            nMismatched++;
            $display("[TB] FAIL midrun_reset: got busy=%b done=%b cov=%h tt=%h want 0 0 0000 0000", busIf.busy, busIf.done, busIf.cover_mask, busIf.truth_table);
        end
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'd8, g[8], 8);
        applyStimulus(4'd9, ~g[9], 8);
        busIf.vec_valid = 1'b0;
        nCompared++;
        if (busIf.busy !== 1'b0 || busIf.cover_mask !== 16'h0 || busIf.err_count !== 5'd0) begin
            nMismatched++;
            $display("[TB] FAIL post_reset_idle: got busy=%b cov=%h err=%0d want 0 0000 0", busIf.busy, busIf.cover_mask, busIf.err_count);
        end
    endtask

`ifdef LAB1_CHK_SIGNATURE_EN
    task automatic test_signature();
        logic [15:0] g;
        logic [15:0] sig;
        g   = GOLD;
        sig = 16'hFFFF;
        pulseStart();
        for (int v = 0; v < 16; v++) begin
            applyStimulus(4'(v), g[v], 8);
            sig = {sig[14:0], sig[15] ^ sig[13] ^ sig[12] ^ sig[10]} ^ {11'b0, g[v], 4'(v)};
        end
        nCompared++;
        if (busIf.signature !== sig) begin
            nMismatched++;
            $display("[TB] FAIL sig_sweep: got %h want %h", busIf.signature, sig);
        end
        pulseStart();
        nCompared++;
        if (busIf.signature !== 16'hFFFF) begin
            nMismatched++;
            $display("[TB] FAIL sig_restart: got %h want ffff", busIf.signature);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ascending();
        test_errors();
        test_glitch();
        test_partial_then_last();
        test_duplicates();
        test_start_priority();
        test_reset_midrun();
`ifdef LAB1_CHK_SIGNATURE_EN
        test_signature();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/lab1_response_checker.md
Name: lab1_response_checker

Overview:
- Response-side counterpart to the Lab1 exhaustive stimulus driver.
- Watches the 4-bit vector {A,B,C,D} applied to a Lab1 combinational DUT and the DUT output F.
- After a settle window, samples F and builds the DUT's 16-entry truth table.
- Compares each sample against a golden table and reports pass/fail once all 16 vectors are covered.

Parameters:
- SETTLE_CYCLES, 4, clock cycles to wait after a new vector before sampling F; legal range 1..255.
- GOLDEN, 16'hB4E1, expected F per vector; bit i is the expected F for vec==i (vec = {A,B,C,D}, A is the MSB).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; clears all results and arms the checker.
- vec_valid  input  1  high while vec holds a driven vector.
- vec  input  4  applied vector {A,B,C,D}.
- f  input  1  DUT output F.
- busy  output  1  high in ARMED, SETTLE or SAMPLE.
- done  output  1  high in DONE; held until start or reset.
- pass  output  1  valid when done; 1 iff err_count==0.
- truth_table  output  16  captured F values; bit i = last F sampled for vec i.
- cover_mask  output  16  bit i is set once vec i has been sampled.
- err_count  output  5  number of mismatching samples; saturates at 31.
- first_err_valid  output  1  set on the first mismatch.
- first_err_vec  output  4  vec of the first mismatch.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; all outputs 0; internal cnt, last_vec and have_last cleared.
- States: IDLE, ARMED, SETTLE, SAMPLE, DONE.
- IDLE: start -> ARMED, with truth_table, cover_mask, err_count, first_err_* and have_last cleared. Other inputs are ignored.
- ARMED: a vector is accepted when vec_valid=1 and (have_last=0 or vec!=last_vec). Acceptance -> SETTLE with cnt=0 and vec latched as cur_vec. Otherwise stay in ARMED.
- SETTLE:
  - cnt increments each cycle.
  - If vec_valid drops or vec!=cur_vec: cur_vec is re-latched if vec_valid=1 and cnt resets to 0; if vec_valid=0, return to ARMED.
  - When cnt==SETTLE_CYCLES-1 and the vector is stable: -> SAMPLE.
- SAMPLE (exactly 1 cycle), at the end of the cycle:
  - truth_table[cur_vec] <= f; cover_mask[cur_vec] <= 1.
  - If f != GOLDEN[cur_vec]: err_count increments (saturating at 31). If first_err_valid=0, first_err_vec <= cur_vec and first_err_valid <= 1.
  - last_vec <= cur_vec; have_last <= 1.
  - Next state: DONE if the updated cover_mask==16'hFFFF, else ARMED.
- Latency: the sample is registered SETTLE_CYCLES+1 clocks after the acceptance edge. Results are visible on the following cycle.
- Duplicates: re-applying an already-covered vector (non-consecutively) is re-sampled. truth_table is overwritten and a mismatch counts again. Holding the same vector consecutively does not re-trigger a sample.
- DONE: pass = (err_count==0); done=1, busy=0. Inputs are ignored except start.
- start in any non-IDLE state (including mid-SETTLE): same clearing as from IDLE; next state=ARMED. start takes priority over sampling in the same cycle.
- Reset mid-run: immediate return to reset values; no partial result is retained.
- pass is 0 whenever done=0.

Optional Feature:
- Macro: LAB1_CHK_SIGNATURE_EN.
- Defined:
  - Adds output signature [15:0], reset value 16'hFFFF, set to 16'hFFFF on start.
  - Each SAMPLE cycle: signature <= {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} ^ {11'b0, f, cur_vec}. This is a MISR over the ordered sample stream.
- Undefined: no signature port and no MISR logic. All other behaviour is identical.

Test Plan:
- Ascending sweep: reset, start, drive vec 0..15 each held 8 cycles with f=GOLDEN[vec] -> done=1, pass=1, truth_table=16'hB4E1, cover_mask=16'hFFFF, err_count=0.
- Inverted F on vec 3 and vec 9, rest correct -> done=1, pass=0, err_count=2, first_err_vec=4'd3, truth_table=16'hB6E9.
- Glitch: vec=5 held 2 cycles, then vec=6 held 8 cycles -> vec 5 not sampled (cover_mask[5]=0, cover_mask[6]=1); busy stays 1; no errors.
- Sweep 0..14 only -> done stays 0, busy=1, cover_mask=16'h7FFF. Then vec=15 correct -> done=1 within SETTLE_CYCLES+2 clocks.
- Reset mid-run: assert rst_n=0 during SETTLE of vec 7 -> all outputs 0 immediately, state IDLE. Vectors without start are ignored.
- Signature (macro defined): ascending sweep with golden F -> signature matches the bench's reference MISR model. A second start clears it to 16'hFFFF.
